// File: rtl/ddrphy_vref_pda_dq_gen.sv
// ddrphy_vref_pda_dq_gen
//   DQ drive generator for per-DRAM-addressable (PDA) mode-register writes
//   during VREF training. After a latched write latency it drives the DQ
//   nibbles of selected devices low and all other nibbles high for a
//   latched window, then pulses pda_ack.
//
//   Optional feature macro: DWC_VREF_PDA_POSTAMBLE_EN
//     defined   -> one POST cycle after DRIVE (oe on, data all ones)
//     undefined -> DRIVE goes straight to DONE
//
// Ports
//   ctl_clk, ctl_rst   controller clock, async active-high reset
//   x8mode             x8 DRAM: odd nibble follows even nibble (2 DQS/byte only)
//   pda_req            start request, sampled in IDLE only
//   pda_abort          abandon sequence (ignored in IDLE)
//   pda_lane_sel       per-nibble device select (1 = drive 0)
//   wl_cycles          cycles from accept to first drive cycle
//   drv_cycles         drive window length (0 behaves as 1)
//   pda_busy           sequence in progress
//   pda_ack            1-cycle completion pulse
//   pda_err            1-cycle pulse: x8 even/odd select mismatch at accept
//   dq_oe, dq_out      per-nibble output enable and DQ data
module ddrphy_vref_pda_dq_gen #(
    parameter int pNO_OF_DX_DQS = 2,
    parameter int pNO_OF_BYTES  = 4,
    parameter int pNUM_LANES    = pNO_OF_DX_DQS * pNO_OF_BYTES,
    parameter int pWL_W         = 6
) (
    input  logic                    ctl_clk,
    input  logic                    ctl_rst,
    input  logic                    x8mode,
    input  logic                    pda_req,
    input  logic                    pda_abort,
    input  logic [pNUM_LANES-1:0]   pda_lane_sel,
    input  logic [pWL_W-1:0]        wl_cycles,
    input  logic [3:0]              drv_cycles,
    output logic                    pda_busy,
    output logic                    pda_ack,
    output logic                    pda_err,
    output logic [pNUM_LANES-1:0]   dq_oe,
    output logic [4*pNUM_LANES-1:0] dq_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_DRIVE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef DWC_VREF_PDA_POSTAMBLE_EN
    localparam logic [2:0] S_POST  = 3'd4;
`endif

    logic [2:0]              state, state_nxt;
    logic [pWL_W-1:0]        wl_cnt;
    logic [3:0]              drv_cnt;
    logic [pNUM_LANES-1:0]   sel_eff, sel_q, sel_use;
    logic [4*pNUM_LANES-1:0] dq_out_nxt;
    logic                    pair_err, accept;
    logic                    drive_nxt, post_nxt, busy_nxt;

    // Effective select: in x8 mode the even nibble owns the device, so the
    // odd nibble copies it; a disagreeing pair is flagged but not blocked.
    if (pNO_OF_DX_DQS == 2) begin : g_x2
        logic [pNUM_LANES/2-1:0] mism;
        for (genvar j = 0; j < pNUM_LANES/2; j++) begin : g_pair
            assign sel_eff[2*j]   = pda_lane_sel[2*j];
            assign sel_eff[2*j+1] = x8mode ? pda_lane_sel[2*j] : pda_lane_sel[2*j+1];
            assign mism[j]        = x8mode & (pda_lane_sel[2*j] ^ pda_lane_sel[2*j+1]);
        end
        assign pair_err = |mism;
    end else begin : g_x1
        logic unused_x8;
        assign unused_x8 = x8mode;
        assign sel_eff   = pda_lane_sel;
        assign pair_err  = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE:
                if (pda_req) begin
                    accept    = 1'b1;
                    state_nxt = (wl_cycles == '0) ? S_DRIVE : S_WAIT;
                end
            S_WAIT:
                if (wl_cnt <= pWL_W'(1)) state_nxt = S_DRIVE;
            S_DRIVE:
`ifdef DWC_VREF_PDA_POSTAMBLE_EN
                if (drv_cnt <= 4'd1) state_nxt = S_POST;
            S_POST:
                state_nxt = S_DONE;
`else
                if (drv_cnt <= 4'd1) state_nxt = S_DONE;
`endif
            S_DONE:
                state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
        if (pda_abort && state != S_IDLE) state_nxt = S_IDLE;
    end

    // Outputs are registered from the next state, so the pattern must come
    // from the live select on the accept edge (wl_cycles==0 drives at once).
    assign sel_use   = accept ? sel_eff : sel_q;
    assign drive_nxt = (state_nxt == S_DRIVE);
`ifdef DWC_VREF_PDA_POSTAMBLE_EN
    assign post_nxt  = (state_nxt == S_POST);
`else
    assign post_nxt  = 1'b0;
`endif
    assign busy_nxt  = (state_nxt == S_WAIT) | drive_nxt | post_nxt;

    for (genvar k = 0; k < pNUM_LANES; k++) begin : g_lane
        assign dq_out_nxt[4*k +: 4] = (drive_nxt && sel_use[k]) ? 4'h0 : 4'hF;
    end

    always_ff @(posedge ctl_clk or posedge ctl_rst) begin
        if (ctl_rst) begin
            state    <= S_IDLE;
            wl_cnt   <= '0;
            drv_cnt  <= '0;
            sel_q    <= '0;
            pda_busy <= 1'b0;
            pda_ack  <= 1'b0;
            pda_err  <= 1'b0;
            dq_oe    <= '0;
            dq_out   <= '1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wl_cnt  <= wl_cycles;
                drv_cnt <= (drv_cycles == 4'd0) ? 4'd1 : drv_cycles;
                sel_q   <= sel_eff;
            end else begin
                if (state == S_WAIT)  wl_cnt  <= wl_cnt - pWL_W'(1);
                if (state == S_DRIVE) drv_cnt <= drv_cnt - 4'd1;
            end
            pda_busy <= busy_nxt;
            pda_ack  <= (state_nxt == S_DONE);
            pda_err  <= accept & pair_err;
            dq_oe    <= (drive_nxt | post_nxt) ? '1 : '0;
            dq_out   <= dq_out_nxt;
        end
    end

endmodule

// File: tb/tb_ddrphy_vref_pda_dq_gen.sv
// Directed bench for ddrphy_vref_pda_dq_gen (default 2 DQS x 4 bytes).
// Each stimulus pushes hand-computed per-cycle expectations into a queue;
// a negedge monitor pops one entry whenever the DUT shows activity.
module tb_ddrphy_vref_pda_dq_gen;
    localparam int NL = 8;
`ifdef DWC_VREF_PDA_POSTAMBLE_EN
    localparam int POST = 1;
`else
    localparam int POST = 0;
`endif

    logic              ctl_clk = 1'b0;
    logic              ctl_rst, x8mode, pda_req, pda_abort;
    logic [NL-1:0]     pda_lane_sel;
    logic [5:0]        wl_cycles;
    logic [3:0]        drv_cycles;
    logic              pda_busy, pda_ack, pda_err;
    logic [NL-1:0]     dq_oe;
    logic [4*NL-1:0]   dq_out;

    ddrphy_vref_pda_dq_gen dut (
        .ctl_clk(ctl_clk), .ctl_rst(ctl_rst), .x8mode(x8mode),
        .pda_req(pda_req), .pda_abort(pda_abort), .pda_lane_sel(pda_lane_sel),
        .wl_cycles(wl_cycles), .drv_cycles(drv_cycles),
        .pda_busy(pda_busy), .pda_ack(pda_ack), .pda_err(pda_err),
        .dq_oe(dq_oe), .dq_out(dq_out)
    );

    always #5 ctl_clk = ~ctl_clk;

    int cyc = 0;
    always @(posedge ctl_clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [7:0]  oe;
        logic [31:0] dq;
        logic        ack, err, busy;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: any visible activity must match the next queued expectation.
    always @(negedge ctl_clk) begin
        if (!ctl_rst && (dq_oe != '0 || pda_ack || pda_err)) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_activity: oe=%h dq=%h ack=%b err=%b at cycle %0d",
                         dq_oe, dq_out, pda_ack, pda_err, cyc);
            end else begin
                e = q.pop_front();
                chk("event_cycle", cyc, e.c);
                chk("dq_oe", {24'b0, dq_oe}, {24'b0, e.oe});
                chk("dq_out", dq_out, e.dq);
                chk("pda_ack", {31'b0, pda_ack}, {31'b0, e.ack});
                chk("pda_err", {31'b0, pda_err}, {31'b0, e.err});
                chk("pda_busy", {31'b0, pda_busy}, {31'b0, e.busy});
            end
        end
    end

    // Expected activity for a sequence accepted in cycle n.
    task automatic push_exp(input int n, input int wl, input int d,
                            input logic [31:0] pat, input logic err);
        for (int t = 1; t <= wl + d + POST + 1; t++) begin
            logic dv, ps, ak, er;
            dv = (t >= wl + 1) && (t <= wl + d);
            ps = (POST == 1) && (t == wl + d + 1);
            ak = (t == wl + d + POST + 1);
            er = err && (t == 1);
            if (dv || ps || ak || er)
                q.push_back('{n + t, (dv || ps) ? 8'hFF : 8'h00,
                              dv ? pat : 32'hFFFF_FFFF, ak, er, !ak});
        end
    endtask

    task automatic cycle();
        @(posedge ctl_clk);
        #1;
    endtask

    task automatic run_seq(input logic [7:0] sel, input logic x8, input logic [5:0] wl,
                           input logic [3:0] drv, input logic [31:0] pat,
                           input logic err, input logic abt);
        int n, d;
        pda_lane_sel = sel; x8mode = x8; wl_cycles = wl; drv_cycles = drv;
        pda_req = 1'b1; pda_abort = abt;
        n = cyc;
        d = (drv == 4'd0) ? 1 : int'(drv);
        push_exp(n, int'(wl), d, pat, err);
        cycle();
        pda_req = 1'b0; pda_abort = 1'b0;
        // Inputs latched at accept; these changes must not matter.
        pda_lane_sel = ~sel; x8mode = ~x8; wl_cycles = ~wl; drv_cycles = ~drv;
        chk("busy_after_accept", {31'b0, pda_busy}, 32'd1);
        repeat (int'(wl) + d + POST + 2) cycle();
    endtask

    initial begin
        int n;
        ctl_rst = 1'b1; x8mode = 1'b0; pda_req = 1'b0; pda_abort = 1'b0;
        pda_lane_sel = '0; wl_cycles = '0; drv_cycles = '0;
        #2;
        chk("rst_dq_oe", {24'b0, dq_oe}, 32'd0);
        chk("rst_dq_out", dq_out, 32'hFFFF_FFFF);
        chk("rst_busy", {31'b0, pda_busy}, 32'd0);
        chk("rst_ack", {31'b0, pda_ack}, 32'd0);
        chk("rst_err", {31'b0, pda_err}, 32'd0);
        cycle();
        ctl_rst = 1'b0;
        cycle();

        // Basic x4, x8 merge/mismatch, x8 matched pair, edges
        run_seq(8'b0000_0101, 1'b0, 6'd3, 4'd4, 32'hFFFF_F0F0, 1'b0, 1'b0);
        run_seq(8'b0000_0010, 1'b1, 6'd2, 4'd2, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_seq(8'b0000_0001, 1'b1, 6'd1, 4'd3, 32'hFFFF_FF00, 1'b1, 1'b0);
        run_seq(8'b1100_0000, 1'b1, 6'd2, 4'd1, 32'h00FF_FFFF, 1'b0, 1'b0);
        run_seq(8'b1010_0001, 1'b0, 6'd0, 4'd0, 32'h0F0F_FFF0, 1'b0, 1'b0);
        run_seq(8'b1111_1111, 1'b0, 6'd63, 4'd15, 32'h0000_0000, 1'b0, 1'b0);

        // Abort in DRIVE cycle 2, then a new request one cycle later
        pda_lane_sel = 8'b0001_0000; x8mode = 1'b0; wl_cycles = 6'd1; drv_cycles = 4'd4;
        pda_req = 1'b1; n = cyc;
        q.push_back('{n + 2, 8'hFF, 32'hFFF0_FFFF, 1'b0, 1'b0, 1'b1});
        q.push_back('{n + 3, 8'hFF, 32'hFFF0_FFFF, 1'b0, 1'b0, 1'b1});
        cycle(); pda_req = 1'b0;
        cycle();
        cycle(); pda_abort = 1'b1;
        cycle(); pda_abort = 1'b0;
        chk("abort_dq_oe", {24'b0, dq_oe}, 32'd0);
        chk("abort_busy", {31'b0, pda_busy}, 32'd0);
        run_seq(8'b0000_1000, 1'b0, 6'd2, 4'd2, 32'hFFFF_0FFF, 1'b0, 1'b0);
        // abort together with req in IDLE: accepted
        run_seq(8'b0100_0000, 1'b0, 6'd1, 4'd1, 32'hF0FF_FFFF, 1'b0, 1'b1);

        // req held high: second accept in the cycle after DONE
        pda_lane_sel = 8'b0000_0100; x8mode = 1'b0; wl_cycles = 6'd1; drv_cycles = 4'd2;
        pda_req = 1'b1; n = cyc;
        push_exp(n, 1, 2, 32'hFFFF_F0FF, 1'b0);
        push_exp(n + 5 + POST, 1, 2, 32'hFFFF_F0FF, 1'b0);
        repeat (5 + POST) cycle();
        chk("hold_idle_busy", {31'b0, pda_busy}, 32'd0);
        cycle(); pda_req = 1'b0;
        repeat (1 + 2 + POST + 2) cycle();

        // Reset during WAIT
        pda_lane_sel = 8'b0000_0001; wl_cycles = 6'd5; drv_cycles = 4'd3; pda_req = 1'b1;
        cycle(); pda_req = 1'b0;
        cycle();
        chk("wait_busy", {31'b0, pda_busy}, 32'd1);
        #2 ctl_rst = 1'b1;
        #1;
        chk("rstw_busy", {31'b0, pda_busy}, 32'd0);
        chk("rstw_dq_oe", {24'b0, dq_oe}, 32'd0);
        q.delete();
        cycle(); #2 ctl_rst = 1'b0;
        cycle();

        // Reset during DRIVE
        pda_lane_sel = 8'b0000_0010; wl_cycles = 6'd0; drv_cycles = 4'd8; pda_req = 1'b1;
        n = cyc;
        push_exp(n, 0, 8, 32'hFFFF_FF0F, 1'b0);
        cycle(); pda_req = 1'b0;
        cycle();
        #2 ctl_rst = 1'b1;
        #1;
        chk("rstd_dq_oe", {24'b0, dq_oe}, 32'd0);
        chk("rstd_dq_out", dq_out, 32'hFFFF_FFFF);
        chk("rstd_busy", {31'b0, pda_busy}, 32'd0);
        chk("rstd_ack", {31'b0, pda_ack}, 32'd0);
        q.delete();
        cycle(); #2 ctl_rst = 1'b0;
        cycle();
        run_seq(8'b0000_0101, 1'b0, 6'd3, 4'd4, 32'hFFFF_F0F0, 1'b0, 1'b0);

        repeat (3) cycle();
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
